// File: rtl/ramp_gen_pkg.sv
// Shared constants and helpers for the multi-channel ramp generator.
package ramp_gen_pkg;

    // Register selectors carried on cfg_reg.
    localparam logic [1:0] REG_YSET = 2'd0;
    localparam logic [1:0] REG_RMAX = 2'd1;
    localparam logic [1:0] REG_A    = 2'd2;

    // Sweep sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Saturating signed add. Operands arrive sign-extended to 64 bits and the
    // result is clamped to the signed range of a w-bit word, so a ramp that
    // runs past full scale sticks at the rail rather than wrapping.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [65:0] sum;
        logic signed [65:0] hi;
        logic signed [65:0] lo;
        sum = 66'(a) + 66'(b);
        hi  = (66'sd1 <<< (w - 1)) - 66'sd1;
        lo  = -(66'sd1 <<< (w - 1));
        if (sum > hi)
            sat_add = hi[63:0];
        else if (sum < lo)
            sat_add = lo[63:0];
        else
            sat_add = sum[63:0];
    endfunction

endpackage

// File: rtl/ramp_gen_mc_if.sv
// Host configuration bus for the ramp generator: 16-bit shadow writes and
// per-channel commit strobes.
interface ramp_gen_mc_if #(
    parameter int W = 32
);
    localparam int WW = (W > 16) ? $clog2(W / 16) : 1;

    logic          cfg_we;
    logic [3:0]    cfg_ch;
    logic [1:0]    cfg_reg;
    logic [WW-1:0] cfg_word;
    logic [15:0]   cfg_data;
    logic          cfg_commit;

    modport master (
        output cfg_we, cfg_ch, cfg_reg, cfg_word, cfg_data, cfg_commit
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_reg, cfg_word, cfg_data, cfg_commit
    );
endinterface

// File: rtl/ramp_step.sv
// Single-channel step of the ramp: works out the next rate and output from
// the current state and the channel's limits. Purely combinational; the top
// time-shares one copy across all channels.
module ramp_step
    import ramp_gen_pkg::*;
#(
    parameter int W = 32
) (
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] r,
    input  logic signed [W-1:0] yset,
    input  logic signed [W-1:0] rmax,
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] y_next,
    output logic signed [W-1:0] r_next
);
    // Wide enough that the distance, the squared rate and 2*A*|d| never overflow.
    localparam int P = 2 * W + 4;

    logic signed [P-1:0] y_w, r_w, ys_w, rm_w, a_w;
    logic signed [P-1:0] d_w, abs_d, abs_r, sr, mag;
    logic signed [P-1:0] brake_lhs, brake_rhs;
    logic                pos;

    // Pick one of freeze / snap / brake / slow-down / accelerate, then move Y by the new rate.
    always_comb begin
        y_w       = P'(y);
        r_w       = P'(r);
        ys_w      = P'(yset);
        rm_w      = P'(rmax);
        a_w       = P'(a);
        d_w       = ys_w - y_w;
        pos       = !d_w[P-1];
        abs_d     = pos ? d_w : -d_w;
        abs_r     = r_w[P-1] ? -r_w : r_w;
        sr        = pos ? r_w : -r_w;
        brake_lhs = r_w * r_w;
        brake_rhs = (a_w * abs_d) <<< 1;
        mag       = '0;
        y_next    = y;
        r_next    = r;
        if (a[W-1] || (a == '0) || rmax[W-1] || (rmax == '0)) begin
            y_next = y;
            r_next = r;
        end else if ((abs_d <= a_w) && (abs_r <= a_w)) begin
            y_next = yset;
            r_next = '0;
        end else begin
            if (!sr[P-1] && (sr != '0) && (brake_lhs >= brake_rhs)) begin
                mag = abs_r - a_w;
                if (mag < a_w)
                    mag = '0;
            end else if (sr > rm_w) begin
                mag = sr - a_w;
                if (mag < rm_w)
                    mag = rm_w;
            end else begin
                mag = sr + a_w;
                if (mag > rm_w)
                    mag = rm_w;
            end
            r_next = pos ? W'(mag) : W'(-mag);
            y_next = W'(sat_add(64'(y), 64'(r_next), W));
        end
    end

endmodule

// File: rtl/ramp_gen_mc.sv
// Multi-channel rate/acceleration-limited ramp generator. A tick launches one
// sweep that updates each channel in turn through a shared ramp_step; config
// commits that land mid-sweep are held until the sweep finishes.
module ramp_gen_mc
    import ramp_gen_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 32
) (
    input  logic               clk_slow,
    input  logic               nReset,
    input  logic               tick,
    ramp_gen_mc_if.slave       cfg,
    output logic [NCH*W-1:0]   y_out,
    output logic [NCH*W-1:0]   r_out,
    output logic [NCH-1:0]     at_target,
    output logic               busy,
    output logic               sweep_done,
    output logic               overrun
);
    localparam int NW = W / 16;
    localparam int WW = (W > 16) ? $clog2(W / 16) : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic signed [W-1:0] sh_yset [NCH];
    logic signed [W-1:0] sh_rmax [NCH];
    logic signed [W-1:0] sh_a    [NCH];
    logic signed [W-1:0] act_yset[NCH];
    logic signed [W-1:0] act_rmax[NCH];
    logic signed [W-1:0] act_a   [NCH];
    logic signed [W-1:0] y_r     [NCH];
    logic signed [W-1:0] r_r     [NCH];

    logic [1:0]          state;
    logic [CW-1:0]       ch;
    logic [NCH-1:0]      pending;
    logic [NCH-1:0]      commit_mask;
    logic signed [W-1:0] y_nx, r_nx;

    ramp_step #(.W(W)) u_step (
        .y      (y_r[ch]),
        .r      (r_r[ch]),
        .yset   (act_yset[ch]),
        .rmax   (act_rmax[ch]),
        .a      (act_a[ch]),
        .y_next (y_nx),
        .r_next (r_nx)
    );

    // Decode the commit strobe into a one-hot channel mask (out-of-range channels hit nothing).
    always_comb begin
        commit_mask = '0;
        for (int i = 0; i < NCH; i++)
            if (cfg.cfg_commit && (cfg.cfg_ch == 4'(i)))
                commit_mask[i] = 1'b1;
    end

    // Shadow registers take host words straight away, whatever the sweep is doing.
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            for (int i = 0; i < NCH; i++) begin
                sh_yset[i] <= '0;
                sh_rmax[i] <= '0;
                sh_a[i]    <= '0;
            end
        end else if (cfg.cfg_we) begin
            for (int i = 0; i < NCH; i++)
                for (int k = 0; k < NW; k++)
                    if ((cfg.cfg_ch == 4'(i)) && (cfg.cfg_word == WW'(k))) begin
                        case (cfg.cfg_reg)
                            REG_YSET: sh_yset[i][k*16 +: 16] <= cfg.cfg_data;
                            REG_RMAX: sh_rmax[i][k*16 +: 16] <= cfg.cfg_data;
                            REG_A:    sh_a[i][k*16 +: 16]    <= cfg.cfg_data;
                            default:  ;
                        endcase
                    end
        end
    end

    // Sweep sequencer: commits, channel walk, per-channel state update and status flags.
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state      <= ST_IDLE;
            ch         <= '0;
            pending    <= '0;
            sweep_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                y_r[i]      <= '0;
                r_r[i]      <= '0;
                act_yset[i] <= '0;
                act_rmax[i] <= '0;
                act_a[i]    <= '0;
            end
        end else begin
            sweep_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    for (int i = 0; i < NCH; i++)
                        if (commit_mask[i]) begin
                            act_yset[i] <= sh_yset[i];
                            act_rmax[i] <= sh_rmax[i];
                            act_a[i]    <= sh_a[i];
                        end
                    if (tick) begin
                        state <= ST_RUN;
                        ch    <= '0;
                    end
                end
                ST_RUN: begin
                    if (tick)
                        overrun <= 1'b1;
                    pending <= pending | commit_mask;
                    y_r[ch] <= y_nx;
                    r_r[ch] <= r_nx;
                    if (ch == CW'(NCH - 1))
                        state <= ST_DONE;
                    else
                        ch <= ch + CW'(1);
                end
                ST_DONE: begin
                    if (tick)
                        overrun <= 1'b1;
                    for (int i = 0; i < NCH; i++)
                        if (pending[i] || commit_mask[i]) begin
                            act_yset[i] <= sh_yset[i];
                            act_rmax[i] <= sh_rmax[i];
                            act_a[i]    <= sh_a[i];
                        end
                    pending    <= '0;
                    sweep_done <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Flatten channel state onto the output buses and flag channels sitting at rest on target.
    always_comb begin
        busy = (state != ST_IDLE);
        for (int i = 0; i < NCH; i++) begin
            y_out[i*W +: W] = y_r[i];
            r_out[i*W +: W] = r_r[i];
            at_target[i]    = (y_r[i] == act_yset[i]) && (r_r[i] == '0);
        end
    end

endmodule

// File: tb/tb_ramp_gen_mc.sv
// Directed bench for ramp_gen_mc (NCH=4, W=32) with hand-computed ramp tables.
module tb_ramp_gen_mc;
    import ramp_gen_pkg::*;

    logic          clk_slow = 1'b0;
    logic          nReset;
    logic          tick;
    logic [127:0]  y_out;
    logic [127:0]  r_out;
    logic [3:0]    at_target;
    logic          busy;
    logic          sweep_done;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    ramp_gen_mc_if #(.W(32)) cfg_bus ();

    ramp_gen_mc #(.NCH(4), .W(32)) dut (
        .clk_slow   (clk_slow),
        .nReset     (nReset),
        .tick       (tick),
        .cfg        (cfg_bus),
        .y_out      (y_out),
        .r_out      (r_out),
        .at_target  (at_target),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun)
    );

    always #5 clk_slow = ~clk_slow;

    // Hand-derived ramps: ch0 0->100 (Rmax 10, A 2), ch1 0->-50 (Rmax 5, A 1).
    int exp_y0 [15] = '{2, 6, 12, 20, 30, 40, 50, 60, 70, 80, 88, 94, 98, 100, 100};
    int exp_r0 [15] = '{2, 4, 6, 8, 10, 10, 10, 10, 10, 10, 8, 6, 4, 2, 0};
    int exp_y1 [15] = '{-1, -3, -6, -10, -15, -20, -25, -30, -35, -40, -44, -47, -49, -50, -50};
    int exp_r1 [15] = '{-1, -2, -3, -4, -5, -5, -5, -5, -5, -5, -4, -3, -2, -1, 0};

    // ch0 retargeted to 200, then to 0 by a commit made mid-sweep.
    int exp_y5 [9] = '{102, 106, 112, 120, 126, 130, 132, 132, 130};
    int exp_r5 [9] = '{2, 4, 6, 8, 6, 4, 2, 0, -2};

    function automatic logic signed [31:0] y_of(input int c);
        return y_out[c*32 +: 32];
    endfunction

    function automatic logic signed [31:0] r_of(input int c);
        return r_out[c*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] c, input logic [1:0] rg, input logic w, input logic [15:0] d);
        cfg_bus.cfg_ch   = c;
        cfg_bus.cfg_reg  = rg;
        cfg_bus.cfg_word = w;
        cfg_bus.cfg_data = d;
        cfg_bus.cfg_we   = 1'b1;
        step();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic set_reg(input logic [3:0] c, input logic [1:0] rg, input logic [31:0] v);
        cfg_write(c, rg, 1'b0, v[15:0]);
        cfg_write(c, rg, 1'b1, v[31:16]);
    endtask

    task automatic commit(input logic [3:0] c);
        cfg_bus.cfg_ch     = c;
        cfg_bus.cfg_commit = 1'b1;
        step();
        cfg_bus.cfg_commit = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sweep_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL sweep_done_timeout: got no sweep_done within 20 cycles, required one");
        end
    endtask

    task automatic do_sweep();
        pulse_tick();
        wait_done();
        step();
        step();
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        step();
        step();
        checks++; if (y_out !== '0)        begin errors++; $display("[TB] FAIL reset_y_out: got %h required 0", y_out); end
        checks++; if (r_out !== '0)        begin errors++; $display("[TB] FAIL reset_r_out: got %h required 0", r_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_sweep_done: got %b required 0", sweep_done); end
        checks++; if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL reset_overrun: got %b required 0", overrun); end
        checks++; if (at_target !== 4'hF)  begin errors++; $display("[TB] FAIL reset_at_target: got %h required F", at_target); end
        nReset = 1'b1;
        step();
    endtask

    task automatic test_two_channel_ramp();
        logic [3:0] exp_at;
        set_reg(4'd0, REG_YSET, 32'd100);
        set_reg(4'd0, REG_RMAX, 32'd10);
        set_reg(4'd0, REG_A,    32'd2);
        set_reg(4'd1, REG_YSET, -32'sd50);
        set_reg(4'd1, REG_RMAX, 32'd5);
        set_reg(4'd1, REG_A,    32'd1);
        commit(4'd0);
        commit(4'd1);
        for (int i = 0; i < 15; i++) begin
            do_sweep();
            exp_at = (i == 14) ? 4'hF : 4'hC;
            checks++; if (y_of(0) !== exp_y0[i]) begin errors++; $display("[TB] FAIL ramp_ch0_y sweep %0d: got %0d required %0d", i + 1, y_of(0), exp_y0[i]); end
            checks++; if (r_of(0) !== exp_r0[i]) begin errors++; $display("[TB] FAIL ramp_ch0_r sweep %0d: got %0d required %0d", i + 1, r_of(0), exp_r0[i]); end
            checks++; if (y_of(1) !== exp_y1[i]) begin errors++; $display("[TB] FAIL ramp_ch1_y sweep %0d: got %0d required %0d", i + 1, y_of(1), exp_y1[i]); end
            checks++; if (r_of(1) !== exp_r1[i]) begin errors++; $display("[TB] FAIL ramp_ch1_r sweep %0d: got %0d required %0d", i + 1, r_of(1), exp_r1[i]); end
            checks++; if (y_out[127:64] !== '0)  begin errors++; $display("[TB] FAIL ramp_ch23_idle sweep %0d: got %h required 0", i + 1, y_out[127:64]); end
            checks++; if (at_target !== exp_at)  begin errors++; $display("[TB] FAIL ramp_at_target sweep %0d: got %h required %h", i + 1, at_target, exp_at); end
        end
    endtask

    task automatic test_overrun();
        int done_cnt = 0;
        int done_at  = -1;
        logic busy_at_done = 1'b1;
        pulse_tick();
        for (int c = 1; c <= 15; c++) begin
            step();
            tick = (c == 1);
            if (sweep_done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = c;
                    busy_at_done = busy;
                end
            end
        end
        tick = 1'b0;
        checks++; if (overrun !== 1'b1)      begin errors++; $display("[TB] FAIL overrun_flag: got %b required 1", overrun); end
        checks++; if (done_cnt != 1)         begin errors++; $display("[TB] FAIL overrun_done_count: got %0d required 1", done_cnt); end
        checks++; if (done_at != 5)          begin errors++; $display("[TB] FAIL overrun_done_cycle: got %0d required 5", done_at); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL overrun_busy_at_done: got %b required 0", busy_at_done); end
        checks++; if (y_of(0) !== 32'sd100)  begin errors++; $display("[TB] FAIL overrun_ch0_hold: got %0d required 100", y_of(0)); end
    endtask

    task automatic test_midramp_commit();
        set_reg(4'd0, REG_YSET, 32'd200);
        commit(4'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                set_reg(4'd0, REG_YSET, 32'd0);
                pulse_tick();
                cfg_bus.cfg_ch     = 4'd0;
                cfg_bus.cfg_commit = 1'b1;
                step();
                cfg_bus.cfg_commit = 1'b0;
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midramp_busy_at_commit: got %b required 1", busy); end
                wait_done();
                step();
                step();
            end else begin
                do_sweep();
            end
            checks++; if (y_of(0) !== exp_y5[i]) begin errors++; $display("[TB] FAIL midramp_ch0_y sweep %0d: got %0d required %0d", i + 1, y_of(0), exp_y5[i]); end
            checks++; if (r_of(0) !== exp_r5[i]) begin errors++; $display("[TB] FAIL midramp_ch0_r sweep %0d: got %0d required %0d", i + 1, r_of(0), exp_r5[i]); end
        end
        checks++; if (y_of(1) !== -32'sd50) begin errors++; $display("[TB] FAIL midramp_ch1_hold: got %0d required -50", y_of(1)); end
    endtask

    task automatic test_saturation_freeze();
        logic signed [31:0] ey [5];
        logic signed [31:0] er [5];
        ey = '{32'sh20000000, 32'sh60000000, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh7FFFFFFF};
        er = '{32'sh20000000, 32'sh40000000, 32'sh20000000, 32'sh20000000, 32'sh20000000};
        set_reg(4'd2, REG_YSET, 32'h7FFF_FFFF);
        set_reg(4'd2, REG_RMAX, 32'h4000_0000);
        set_reg(4'd2, REG_A,    32'h2000_0000);
        commit(4'd2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                set_reg(4'd2, REG_A, 32'd0);
                pulse_tick();
                commit(4'd2);
                wait_done();
                step();
                step();
            end else begin
                do_sweep();
            end
            checks++; if (y_of(2) !== ey[i]) begin errors++; $display("[TB] FAIL sat_ch2_y sweep %0d: got %h required %h", i + 1, y_of(2), ey[i]); end
            checks++; if (r_of(2) !== er[i]) begin errors++; $display("[TB] FAIL sat_ch2_r sweep %0d: got %h required %h", i + 1, r_of(2), er[i]); end
        end
        checks++; if (at_target[2] !== 1'b0) begin errors++; $display("[TB] FAIL sat_at_target2: got %b required 0", at_target[2]); end
        checks++; if (y_of(3) !== 32'sd0)    begin errors++; $display("[TB] FAIL sat_ch3_idle: got %0d required 0", y_of(3)); end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt = 0;
        pulse_tick();
        step();
        nReset = 1'b0;
        step();
        checks++; if (y_out !== '0)       begin errors++; $display("[TB] FAIL midreset_y_out: got %h required 0", y_out); end
        checks++; if (r_out !== '0)       begin errors++; $display("[TB] FAIL midreset_r_out: got %h required 0", r_out); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_overrun: got %b required 0", overrun); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL midreset_busy: got %b required 0", busy); end
        checks++; if (at_target !== 4'hF) begin errors++; $display("[TB] FAIL midreset_at_target: got %h required F", at_target); end
        nReset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (sweep_done)
                done_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d required 0", done_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nReset              = 1'b0;
        tick                = 1'b0;
        cfg_bus.cfg_we      = 1'b0;
        cfg_bus.cfg_ch      = 4'd0;
        cfg_bus.cfg_reg     = 2'd0;
        cfg_bus.cfg_word    = 1'b0;
        cfg_bus.cfg_data    = 16'd0;
        cfg_bus.cfg_commit  = 1'b0;
        $display("[TB] ramp_gen_mc directed tests start");
        test_reset();
        test_two_channel_ramp();
        test_overrun();
        test_midramp_commit();
        test_saturation_freeze();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
